// File: rtl/inst_encoder_pkg.sv
// Instruction-format definitions (widths, opcodes, functs, tuple kinds, FSM codes) and packing helpers.
// Optional build macro ENC_CHECK_EN enables opcode/funct legality checks (see enc_is_legal).
`ifndef INST_DEF_V
`define INST_DEF_V
`define INST_W      16
`define OPCODE_W    4
`define R_FUNC_W    4
`define RF_ADDR_W   4
`define IMM_W       8
`define FR_FUNC_W   3
`define OP_R        4'h0
`define OP_ADDI     4'h1
`define OP_LDI      4'h2
`define OP_LD       4'h3
`define OP_ST       4'h4
`define OP_B        4'hF
`define R_FUNC_ADD  4'h1
`define R_FUNC_SUB  4'h2
`define R_FUNC_AND  4'h3
`define R_FUNC_OR   4'h4
`define R_FUNC_XOR  4'h5
`define R_FUNC_SLL  4'h6
`define R_FUNC_SRL  4'h7
`define R_FUNC_MOV  4'h8
`define ENC_KIND_R   2'd0
`define ENC_KIND_I   2'd1
`define ENC_KIND_B   2'd2
`define ENC_KIND_RSV 2'd3
`define ENC_ST_IDLE  2'd0
`define ENC_ST_LOAD  2'd1
`define ENC_ST_DRAIN 2'd2
`define ENC_ST_DONE  2'd3
`endif

package inst_encoder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = `ENC_ST_IDLE,
      ST_LOAD  = `ENC_ST_LOAD,
      ST_DRAIN = `ENC_ST_DRAIN,
      ST_DONE  = `ENC_ST_DONE
   } enc_state_e;

   // Bit layout must match the instruction decoder exactly.
   function automatic logic [`INST_W-1:0] enc_pack(
      input logic [1:0]            kind,
      input logic [`OPCODE_W-1:0]  op,
      input logic [`R_FUNC_W-1:0]  func,
      input logic [`RF_ADDR_W-1:0] rd,
      input logic [`RF_ADDR_W-1:0] rs,
      input logic [`IMM_W-1:0]     imm,
      input logic [`FR_FUNC_W-1:0] fr_func,
      input logic                  imr_sel
   );
      logic [`INST_W-1:0] w_word;
      w_word = '0;
      case (kind)
         `ENC_KIND_R: w_word = {`OP_R, func, rs, rd};
         `ENC_KIND_I: w_word = {op, imm, rd};
         `ENC_KIND_B: w_word = {`OP_B, imr_sel, fr_func, imm};
         default:     w_word = '0;
      endcase
      return w_word;
   endfunction

   function automatic logic enc_is_legal(
      input logic [1:0]           kind,
      input logic [`OPCODE_W-1:0] op,
      input logic [`R_FUNC_W-1:0] func
   );
      logic w_ok;
      w_ok = 1'b0;
      case (kind)
         `ENC_KIND_R: begin
            case (func)
               `R_FUNC_ADD, `R_FUNC_SUB, `R_FUNC_AND, `R_FUNC_OR,
               `R_FUNC_XOR, `R_FUNC_SLL, `R_FUNC_SRL, `R_FUNC_MOV: w_ok = 1'b1;
               default: w_ok = 1'b0;
            endcase
         end
         `ENC_KIND_I: begin
            case (op)
               `OP_ADDI, `OP_LDI, `OP_LD, `OP_ST: w_ok = 1'b1;
               default: w_ok = 1'b0;
            endcase
         end
         `ENC_KIND_B: w_ok = 1'b1;
         default:     w_ok = 1'b0;
      endcase
      return w_ok;
   endfunction

endpackage

// File: rtl/inst_encoder_fifo.sv
// enc_fifo: synchronous packed-word FIFO with registered full/empty/count flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module enc_fifo import inst_encoder_pkg::*; #(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_push,
   input  logic [`INST_W-1:0]         i_data,
   input  logic                       i_pop,
   output logic [`INST_W-1:0]         o_data,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [`INST_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]   r_wp, r_rp;
   logic [CNT_W-1:0]   r_count, w_count_nxt;
   logic               r_full, r_empty;
   logic               w_do_push, w_do_pop;

   // A push into a full FIFO is legal only when a pop frees the slot in the same cycle.
   assign w_do_pop  = i_pop & ~r_empty;
   assign w_do_push = i_push & (~r_full | w_do_pop);

   // Occupancy after this cycle's push/pop.
   always_comb begin
      w_count_nxt = r_count;
      case ({w_do_push, w_do_pop})
         2'b10:   w_count_nxt = r_count + CNT_ONE;
         2'b01:   w_count_nxt = r_count - CNT_ONE;
         default: w_count_nxt = r_count;
      endcase
   end

   // Pointers, occupancy and flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         if (w_do_push) r_wp <= r_wp + PTR_ONE;
         if (w_do_pop)  r_rp <= r_rp + PTR_ONE;
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == CNT_FULL);
         r_empty <= (w_count_nxt == '0);
      end
   end

   // Storage array.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_do_push) begin
         r_mem[r_wp] <= i_data;
      end
   end

   assign o_data  = r_mem[r_rp];
   assign o_full  = r_full;
   assign o_empty = r_empty;
   assign o_count = r_count;
endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded instruction tuples into words and writes them sequentially to IMEM.
// Build macro ENC_CHECK_EN drops and flags tuples with undefined opcodes/functs.
module inst_encoder import inst_encoder_pkg::*; #(
   parameter int ADDR_W     = 8,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     start_addr,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_last,
   input  logic [1:0]            in_kind,
   input  logic [`OPCODE_W-1:0]  in_op,
   input  logic [`R_FUNC_W-1:0]  in_func,
   input  logic [`RF_ADDR_W-1:0] in_rd,
   input  logic [`RF_ADDR_W-1:0] in_rs,
   input  logic [`IMM_W-1:0]     in_imm,
   input  logic [`FR_FUNC_W-1:0] in_fr_func,
   input  logic                  in_imr_sel,
   output logic                  im_we,
   output logic [ADDR_W-1:0]     im_addr,
   output logic [`INST_W-1:0]    im_wdata,
   input  logic                  im_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [ADDR_W:0]       word_cnt
);
   localparam int CNT_W = $clog2(FIFO_DEPTH+1);
   localparam logic [CNT_W-1:0]  LAST_SLOT = CNT_W'(FIFO_DEPTH-1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W:0]   WCNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   WCNT_MAX  = {(ADDR_W+1){1'b1}};

   enc_state_e          r_state, w_state_nxt;
   logic [ADDR_W-1:0]   r_ptr;
   logic [ADDR_W:0]     r_word_cnt;
   logic                r_err;
   logic                r_pend_vld;
   logic [`INST_W-1:0]  r_pend_data;
   logic [`INST_W-1:0]  w_packed, w_head;
   logic                w_full, w_empty, w_accept, w_legal, w_pop;
   logic [CNT_W-1:0]    w_count;

`ifdef ENC_CHECK_EN
   assign w_legal = enc_is_legal(in_kind, in_op, in_func);
`else
   assign w_legal = (in_kind != `ENC_KIND_RSV);
`endif

   assign w_packed = enc_pack(in_kind, in_op, in_func, in_rd, in_rs, in_imm, in_fr_func, in_imr_sel);

   // The in-flight pending word counts as occupied so it can never meet a full FIFO.
   assign in_ready = (r_state == ST_LOAD) & ~w_full & ~(r_pend_vld & (w_count == LAST_SLOT));
   assign w_accept = in_valid & in_ready;
   assign w_pop    = im_we & im_ready;

   enc_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (r_pend_vld),
      .i_data  (r_pend_data),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // Next-state logic for the load sequence.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) w_state_nxt = ST_LOAD;
            else       w_state_nxt = ST_IDLE;
         end
         ST_LOAD: begin
            if (w_accept && in_last) w_state_nxt = ST_DRAIN;
            else                     w_state_nxt = ST_LOAD;
         end
         ST_DRAIN: begin
            if (w_empty && !r_pend_vld) w_state_nxt = ST_DONE;
            else                        w_state_nxt = ST_DRAIN;
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Write pointer, word counter, pending word and sticky error.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ptr       <= '0;
         r_word_cnt  <= '0;
         r_err       <= 1'b0;
         r_pend_vld  <= 1'b0;
         r_pend_data <= '0;
      end else begin
         if (r_state == ST_IDLE && start) begin
            r_ptr      <= start_addr;
            r_word_cnt <= '0;
         end else if (w_pop) begin
            r_ptr <= r_ptr + ADDR_ONE;
            if (r_word_cnt != WCNT_MAX) r_word_cnt <= r_word_cnt + WCNT_ONE;
         end
         r_pend_vld <= w_accept & w_legal;
         if (w_accept) r_pend_data <= w_packed;
         if (w_accept && !w_legal) r_err <= 1'b1;
      end
   end

   assign im_we    = ~w_empty;
   assign im_addr  = r_ptr;
   assign im_wdata = w_head;
   assign busy     = (r_state != ST_IDLE);
   assign done     = (r_state == ST_DONE);
   assign err      = r_err;
   assign word_cnt = r_word_cnt;
endmodule
